// File: rtl/sd_dbg_uart_tx_if.sv
// Debug word stream: producer asserts tvalid with tdata, consumer answers with tready.
interface sd_dbg_uart_tx_if #(
    parameter int DATA_WIDTH = 40
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/sd_dbg_uart_tx.sv
// Debug-word UART transmitter: FIFO-buffered words are printed as 8N1 frames,
// either as uppercase ASCII hex followed by a newline, or as raw bytes MSB first.
module sd_dbg_uart_tx #(
    parameter int DATA_WIDTH   = 40,
    parameter int FIFO_ASIZE   = 9,
    parameter int UART_CLK_DIV = 434,
    parameter int PRINT_MODE   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    sd_dbg_uart_tx_if.slave     dbg,
    output logic                uart_tx,
    output logic [15:0]         stall_cnt,
    output logic [FIFO_ASIZE:0] fifo_level
);
    localparam int NUM_CHARS = (PRINT_MODE == 0) ? (DATA_WIDTH / 4 + 1) : (DATA_WIDTH / 8);
    localparam int IDX_W     = $clog2(NUM_CHARS + 1);
    localparam int BAUD_W    = $clog2(UART_CLK_DIV);
    localparam int DEPTH     = 1 << FIFO_ASIZE;

    // LOAD is the first cycle of a start bit, NEXT the last cycle of a stop bit,
    // so back-to-back characters leave no idle gap on the line.
    typedef enum logic [2:0] {IDLE, POP, LOAD, SHIFT, NEXT} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic [FIFO_ASIZE:0]   wr_ptr_reg;
    logic [FIFO_ASIZE:0]   rd_ptr_reg;
    logic [15:0]           stall_cnt_reg;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] word_reg;
    logic [IDX_W-1:0]      char_idx_reg;
    logic [8:0]            shift_reg;
    logic [BAUD_W-1:0]     baud_cnt_reg;
    logic [3:0]            bit_cnt_reg;
    logic                  uart_tx_reg;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  last_char;
    logic [DATA_WIDTH-1:0] src_word;
    logic [IDX_W-1:0]      src_idx;
    logic [7:0]            next_char;

    // Character number idx of a word: hex nibble (MSB first) then newline, or raw byte.
    function automatic logic [7:0] char_of(input logic [DATA_WIDTH-1:0] w, input logic [IDX_W-1:0] idx);
        logic [3:0] nib;
        nib     = '0;
        char_of = 8'h0A;
        if (PRINT_MODE == 0) begin
            if (int'(idx) < DATA_WIDTH / 4) begin
                nib     = 4'(w >> (DATA_WIDTH - 4 - 4 * int'(idx)));
                char_of = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
            end
        end else begin
            char_of = 8'(w >> (DATA_WIDTH - 8 - 8 * int'(idx)));
        end
    endfunction

    assign empty      = (wr_ptr_reg == rd_ptr_reg);
    assign full       = (wr_ptr_reg[FIFO_ASIZE] != rd_ptr_reg[FIFO_ASIZE]) &&
                        (wr_ptr_reg[FIFO_ASIZE-1:0] == rd_ptr_reg[FIFO_ASIZE-1:0]);
    assign dbg.tready = !full;
    // Blocking on full (not on full-and-no-pop) keeps the write path independent of the FSM.
    assign push       = dbg.tvalid && !full;
    assign last_char  = (char_idx_reg == IDX_W'(NUM_CHARS - 1));
    assign pop        = !empty && ((state_reg == IDLE) || (state_reg == NEXT && last_char));
    assign fifo_level = wr_ptr_reg - rd_ptr_reg;
    assign uart_tx    = uart_tx_reg;
    assign stall_cnt  = stall_cnt_reg;

    // In POP the fresh word comes straight from the RAM output register.
    assign src_word  = (state_reg == POP) ? rd_data_reg : word_reg;
    assign src_idx   = (state_reg == POP) ? '0 : char_idx_reg + IDX_W'(1);
    assign next_char = char_of(src_word, src_idx);

    // Buffer storage: write on accept, registered read on pop; no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[FIFO_ASIZE-1:0]] <= dbg.tdata;
        end
        if (pop) begin
            rd_data_reg <= mem[rd_ptr_reg[FIFO_ASIZE-1:0]];
        end
    end

    // FIFO pointers and saturating backpressure counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (dbg.tvalid && full && stall_cnt_reg != 16'hFFFF) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    // Transmit FSM: fetch a word, then emit its characters as contiguous 10-bit frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            word_reg     <= '0;
            char_idx_reg <= '0;
            shift_reg    <= '1;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            uart_tx_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!empty) begin
                        state_reg <= POP;
                    end
                end
                POP: begin
                    word_reg     <= rd_data_reg;
                    char_idx_reg <= '0;
                    shift_reg    <= {1'b1, next_char};
                    uart_tx_reg  <= 1'b0;
                    baud_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    state_reg    <= LOAD;
                end
                LOAD, SHIFT: begin
                    if (baud_cnt_reg == BAUD_W'(UART_CLK_DIV - 1)) begin
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                        uart_tx_reg  <= shift_reg[0];
                        shift_reg    <= {1'b1, shift_reg[8:1]};
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                    if (bit_cnt_reg == 4'd9 && baud_cnt_reg == BAUD_W'(UART_CLK_DIV - 2)) begin
                        state_reg <= NEXT;
                    end else begin
                        state_reg <= SHIFT;
                    end
                end
                NEXT: begin
                    if (!last_char) begin
                        char_idx_reg <= src_idx;
                        shift_reg    <= {1'b1, next_char};
                        uart_tx_reg  <= 1'b0;
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        state_reg    <= LOAD;
                    end else if (!empty) begin
                        state_reg <= POP;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    uart_tx_reg <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_dbg_uart_tx.sv
// Scoreboard bench: drivers push expected characters, UART receivers pop and compare.
module tb_sd_dbg_uart_tx;
    localparam int DIV     = 4;
    localparam int SAT_DIV = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_dbg_uart_tx_if #(.DATA_WIDTH(40)) hbus ();
    sd_dbg_uart_tx_if #(.DATA_WIDTH(32)) rbus ();
    sd_dbg_uart_tx_if #(.DATA_WIDTH(8))  sbus ();

    logic        htx, rtx, stx;
    logic [15:0] hstall, rstall, sstall;
    logic [2:0]  hlevel, rlevel;
    logic [1:0]  slevel;

    sd_dbg_uart_tx #(.DATA_WIDTH(40), .FIFO_ASIZE(2), .UART_CLK_DIV(DIV), .PRINT_MODE(0)) dut_hex (
        .clk(clk), .rst_n(rst_n), .dbg(hbus), .uart_tx(htx), .stall_cnt(hstall), .fifo_level(hlevel));
    sd_dbg_uart_tx #(.DATA_WIDTH(32), .FIFO_ASIZE(2), .UART_CLK_DIV(DIV), .PRINT_MODE(1)) dut_raw (
        .clk(clk), .rst_n(rst_n), .dbg(rbus), .uart_tx(rtx), .stall_cnt(rstall), .fifo_level(rlevel));
    sd_dbg_uart_tx #(.DATA_WIDTH(8), .FIFO_ASIZE(1), .UART_CLK_DIV(SAT_DIV), .PRINT_MODE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .dbg(sbus), .uart_tx(stx), .stall_cnt(sstall), .fifo_level(slevel));

    logic [7:0] exp_h[$];
    logic [7:0] exp_r[$];
    int checks = 0;
    int errors = 0;
    int h_stalls = 0;
    int h_accepted = 0;
    int bp_seen = 0;
    int bp_accepted = -1;
    int bp_level = -1;
    int s_stalls = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: hex text is one uppercase digit per nibble, MSB first, then a newline.
    function automatic void model_hex(input logic [39:0] w);
        for (int i = 0; i < 10; i++) begin
            int nib;
            nib = int'((w >> (4 * (9 - i))) & 40'hF);
            exp_h.push_back(nib < 10 ? 8'(48 + nib) : 8'(65 + nib - 10));
        end
        exp_h.push_back(8'h0A);
    endfunction

    // Reference: raw mode is the word's bytes, most significant first.
    function automatic void model_raw(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            exp_r.push_back(8'(w >> (8 * (3 - i))));
        end
    endfunction

    function automatic logic line_of(input int ch);
        return (ch == 0) ? htx : rtx;
    endfunction

    // Present a word and hold it until accepted; returns just after the accepting edge.
    task automatic send_word(input int ch, input logic [63:0] w);
        int waited;
        waited = 0;
        @(negedge clk);
        if (ch == 0) begin hbus.tvalid = 1'b1; hbus.tdata = w[39:0]; end
        else begin rbus.tvalid = 1'b1; rbus.tdata = w[31:0]; end
        while (!((ch == 0) ? hbus.tready : rbus.tready) && waited < 6000) begin
            if (ch == 0) begin
                h_stalls++;
                if (bp_seen == 0) begin
                    bp_seen     = 1;
                    bp_accepted = h_accepted;
                    bp_level    = int'(hlevel);
                end
            end
            @(negedge clk);
            waited++;
        end
        check((ch == 0) ? "hex_accept_in_time" : "raw_accept_in_time", 64'(waited < 6000), 64'd1);
        if (waited >= 6000) begin
            hbus.tvalid = 1'b0;
            rbus.tvalid = 1'b0;
            return;
        end
        if (ch == 0) model_hex(w[39:0]);
        else model_raw(w[31:0]);
        $display("push %s word 0x%0h", (ch == 0) ? "hex" : "raw", w);
        @(posedge clk);
        if (ch == 0) h_accepted++;
    endtask

    task automatic wait_drain(input int ch, input int bound);
        int n;
        n = 0;
        while (((ch == 0) ? (exp_h.size() != 0 || hlevel != 0) : (exp_r.size() != 0 || rlevel != 0)) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check((ch == 0) ? "hex_drain_in_time" : "raw_drain_in_time", 64'(n < bound), 64'd1);
        repeat (3 * DIV) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        hbus.tvalid = 1'b0; rbus.tvalid = 1'b0; sbus.tvalid = 1'b0;
        exp_h.delete(); exp_r.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        h_stalls = 0; h_accepted = 0; bp_seen = 0;
        repeat (50) @(negedge clk);
    endtask

    // UART receiver: samples mid-bit and checks each frame against the scoreboard.
    task automatic rx_monitor(input int ch);
        logic [7:0] b;
        logic       start_b, stop_b;
        bit         abort;
        forever begin
            @(negedge clk);
            if (rst_n && line_of(ch) == 1'b0) begin
                b = '0;
                abort = 1'b0;
                repeat (DIV / 2) @(negedge clk);
                start_b = line_of(ch);
                if (!rst_n) abort = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV) @(negedge clk);
                    b[k] = line_of(ch);
                    if (!rst_n) abort = 1'b1;
                end
                repeat (DIV) @(negedge clk);
                stop_b = line_of(ch);
                if (!rst_n) abort = 1'b1;
                if (!abort) begin
                    check((ch == 0) ? "hex_start_bit" : "raw_start_bit", 64'(start_b), 64'd0);
                    check((ch == 0) ? "hex_stop_bit" : "raw_stop_bit", 64'(stop_b), 64'd1);
                    if ((ch == 0) ? (exp_h.size() == 0) : (exp_r.size() == 0)) begin
                        check((ch == 0) ? "hex_unexpected_byte" : "raw_unexpected_byte", 64'(b), 64'h100);
                    end else begin
                        check((ch == 0) ? "hex_byte" : "raw_byte", 64'(b),
                              64'((ch == 0) ? exp_h.pop_front() : exp_r.pop_front()));
                    end
                end
            end
        end
    endtask

    initial rx_monitor(0);
    initial rx_monitor(1);

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lows;
        hbus.tvalid = 1'b0; hbus.tdata = '0;
        rbus.tvalid = 1'b0; rbus.tdata = '0;
        sbus.tvalid = 1'b0; sbus.tdata = '0;
        #12;
        check("rst_hex_tx", 64'(htx), 64'd1);
        check("rst_hex_tready", 64'(hbus.tready), 64'd1);
        check("rst_hex_level", 64'(hlevel), 64'd0);
        check("rst_hex_stall", 64'(hstall), 64'd0);
        check("rst_raw_tx", 64'(rtx), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Latency and frame timing on hex word 0x0123456789.
        send_word(0, 64'h0123456789);
        @(negedge clk);
        hbus.tvalid = 1'b0;
        check("lat_edge_n_tx", 64'(htx), 64'd1);
        check("lat_edge_n_level", 64'(hlevel), 64'd1);
        @(negedge clk);
        check("lat_edge_n1_tx", 64'(htx), 64'd1);
        check("lat_edge_n1_level", 64'(hlevel), 64'd0);
        @(negedge clk);
        check("lat_edge_n2_start", 64'(htx), 64'd0);
        for (int c = 1; c <= 439; c++) begin
            @(negedge clk);
            if (c % 40 == 0) check("hex_frame_no_gap", 64'(htx), 64'd0);
        end
        check("hex_last_stop", 64'(htx), 64'd1);
        check("hex_all_chars_seen", 64'(exp_h.size()), 64'd0);
        lows = 0;
        repeat (20) begin @(negedge clk); if (htx == 1'b0) lows++; end
        check("hex_idle_after_440", 64'(lows), 64'd0);

        // Hex digit map.
        send_word(0, 64'hABCDEF0000);
        @(negedge clk);
        hbus.tvalid = 1'b0;
        wait_drain(0, 1000);

        // Raw mode 0xDEADBEEF: four frames, 160 clocks.
        send_word(1, 64'hDEADBEEF);
        @(negedge clk);
        rbus.tvalid = 1'b0;
        @(negedge clk);
        check("raw_lat_n1_tx", 64'(rtx), 64'd1);
        @(negedge clk);
        check("raw_lat_n2_start", 64'(rtx), 64'd0);
        for (int c = 1; c <= 159; c++) begin
            @(negedge clk);
            if (c % 40 == 0) check("raw_frame_no_gap", 64'(rtx), 64'd0);
        end
        check("raw_all_bytes_seen", 64'(exp_r.size()), 64'd0);
        lows = 0;
        repeat (20) begin @(negedge clk); if (rtx == 1'b0) lows++; end
        check("raw_idle_after_160", 64'(lows), 64'd0);

        // Random words on both channels concurrently.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send_word(0, {24'h0, 8'($urandom), 32'($urandom)});
                    @(negedge clk);
                    hbus.tvalid = 1'b0;
                    repeat ($urandom_range(0, 20)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    send_word(1, {32'h0, 32'($urandom)});
                    @(negedge clk);
                    rbus.tvalid = 1'b0;
                    repeat ($urandom_range(0, 60)) @(negedge clk);
                end
            end
        join
        wait_drain(0, 4000);
        wait_drain(1, 2000);

        // Backpressure: tvalid held high with 10 distinct words from reset.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_word(0, {24'h0, 8'(i), 32'($urandom)});
        end
        @(negedge clk);
        hbus.tvalid = 1'b0;
        check("bp_accepted_before_drop", 64'(bp_accepted), 64'd5);
        check("bp_level_at_drop", 64'(bp_level), 64'd4);
        check("bp_stall_cnt", 64'(hstall), 64'(h_stalls));
        wait_drain(0, 6000);

        // Reset in the middle of data bit 2 with three words queued.
        send_word(0, {24'h0, 4'h0, 36'($urandom)});
        for (int i = 0; i < 3; i++) begin
            send_word(0, {24'h0, 8'($urandom), 32'($urandom)});
        end
        @(negedge clk);
        hbus.tvalid = 1'b0;
        check("mid_level_3_queued", 64'(hlevel), 64'd3);
        check("mid_start_bit", 64'(htx), 64'd0);
        repeat (12) @(negedge clk);
        check("mid_data_bit2_low", 64'(htx), 64'd0);
        rst_n = 1'b0;
        exp_h.delete();
        exp_r.delete();
        #1;
        check("mid_rst_tx_high", 64'(htx), 64'd1);
        check("mid_rst_level", 64'(hlevel), 64'd0);
        check("mid_rst_tready", 64'(hbus.tready), 64'd1);
        check("mid_rst_stall", 64'(hstall), 64'd0);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        send_word(0, {24'h0, 8'($urandom), 32'($urandom)});
        @(negedge clk);
        hbus.tvalid = 1'b0;
        wait_drain(0, 1000);

        // Saturation: slow transmitter, tvalid held high long past 0xFFFF stalls.
        @(negedge clk);
        sbus.tvalid = 1'b1;
        sbus.tdata  = 8'($urandom);
        for (int i = 0; i < 70000; i++) begin
            if (!sbus.tready) s_stalls++;
            @(negedge clk);
            if (i == 999) check("sat_count_tracks", 64'(sstall), 64'(s_stalls));
        end
        check("sat_level_full", 64'(slevel), 64'd2);
        check("sat_reached_ffff", 64'(sstall), 64'hFFFF);
        repeat (50) @(negedge clk);
        check("sat_no_wrap", 64'(sstall), 64'hFFFF);
        sbus.tvalid = 1'b0;

        check("final_hex_queue_empty", 64'(exp_h.size()), 64'd0);
        check("final_raw_queue_empty", 64'(exp_r.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_dbg_uart_tx.md
Name: sd_dbg_uart_tx

Overview:
Single-clock debug-info UART transmitter for the fake SD-card design. It takes fixed-width debug words (e.g. the 40-bit SDFake dbg_wdata stream) over a valid/ready interface and buffers them in a FIFO. Each word is serialised as 8N1 UART, either as ASCII hex text or as raw bytes. It adds a print-mode select, parametrised width and depth, and a saturating backpressure counter.

Parameters:
DATA_WIDTH, 40, debug word width; multiple of 8, range 8..64
FIFO_ASIZE, 9, FIFO address bits; depth = 2**FIFO_ASIZE words; range 1..12
UART_CLK_DIV, 434, clk cycles per UART bit; minimum 2
PRINT_MODE, 0, 0 = ASCII hex plus newline; 1 = raw binary bytes

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
tvalid  input  1  debug word valid
tready  output  1  FIFO can accept a word
tdata  input  DATA_WIDTH  debug word
uart_tx  output  1  UART serial out; idle high
stall_cnt  output  16  count of cycles with tvalid=1 and tready=0; saturating
fifo_level  output  FIFO_ASIZE+1  words currently in the FIFO

Behaviour:
- Reset (asynchronous, effective immediately): uart_tx=1, FIFO empty, fifo_level=0, tready=1, stall_cnt=0, FSM=IDLE. Reset mid-frame aborts the character; the line returns high at once and all queued data is discarded.
- Write handshake:
  - tready = !full, combinational from FIFO state.
  - A word is accepted on a rising edge with tvalid && tready.
  - At full, writes are blocked even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves fifo_level unchanged.
- stall_cnt increments on every edge with tvalid && !tready. It saturates at 0xFFFF and clears only on reset.
- FSM states: IDLE -> POP -> LOAD -> SHIFT -> NEXT.
  - IDLE: if FIFO not empty, go to POP.
  - POP: read the FIFO head into the word register (FIFO read latency of 1 cycle is absorbed here); set char index = 0.
  - LOAD: form the character for the current index and load a 10-bit frame {stop=1, data[7:0], start=0}. uart_tx goes low on this edge.
  - SHIFT: hold each bit for exactly UART_CLK_DIV cycles, LSB first. Frame length is 10*UART_CLK_DIV cycles.
  - NEXT: if more characters remain, increment the index and go to LOAD; else go to POP if FIFO not empty, otherwise IDLE. The gap between consecutive frames is 0 cycles: the next start bit begins immediately after the previous stop-bit period.
- Latency: for a word accepted at edge N with the FSM idle, POP occurs at edge N+1 and the start bit is driven from edge N+2.
- PRINT_MODE=0 (hex):
  - Output is DATA_WIDTH/4 characters, MSB nibble first, uppercase ASCII: 0-9 = 0x30-0x39, A-F = 0x41-0x46.
  - These are followed by 0x0A.
  - Characters per word = DATA_WIDTH/4 + 1.
- PRINT_MODE=1 (raw): DATA_WIDTH/8 bytes, most-significant byte first, with no separator.
- Words are never reordered or split. A word in transmission is unaffected by new pushes.
- All counters and indices wrap only at their defined limits. The FIFO pointers are FIFO_ASIZE+1 bits, with full/empty detected by MSB compare.

Test Plan:
- Hex mode, DATA_WIDTH=40, UART_CLK_DIV=4, one word 0x0123456789 -> 11 frames of 40 clk each: bytes 0x30,0x31,...,0x39,0x0A, LSB first with start=0 and stop=1. Start bit is low from the 2nd edge after acceptance. uart_tx returns high and the FSM is IDLE after 440 clk.
- Hex digit map: word 0xABCDEF0000 -> bytes 0x41,0x42,0x43,0x44,0x45,0x46,0x30,0x30,0x30,0x30,0x0A.
- Raw mode, DATA_WIDTH=32, word 0xDEADBEEF -> frames 0xDE,0xAD,0xBE,0xEF only; total 160 clk at UART_CLK_DIV=4.
- Backpressure, FIFO_ASIZE=2, tvalid held high with 10 distinct words from reset:
  - exactly 5 words accepted before tready first drops (1 popped at edge 1, 4 queued);
  - fifo_level=4 at that point;
  - stall_cnt increments once per blocked cycle;
  - all 10 words are printed in order with no loss.
- Saturation: hold tvalid high with the FIFO full for 70000 cycles -> stall_cnt=0xFFFF and it does not wrap.
- Reset mid-frame: assert rst_n low during the 3rd data bit of a character with 3 words queued -> uart_tx=1 in the same cycle, fifo_level=0, tready=1, stall_cnt=0. After release, a new word prints correctly from its first character.
